// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned MIN_PRESCALE = 4;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit edge counter and data-bit index for the UART transmitter.
module uart_tx_bit_timer #(
  parameter int DATA_W     = 8,
  parameter int prescale_w = 6,
  parameter int IDX_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic                  in_data,
  input  logic [prescale_w-1:0] prescale,
  output logic                  bit_tick,
  output logic [IDX_W-1:0]      bit_idx,
  output logic                  last_bit
);

  logic [prescale_w-1:0] edge_cnt;

  assign bit_tick = en && (edge_cnt == prescale - 1'b1);
  assign last_bit = (bit_idx == IDX_W'(DATA_W - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      edge_cnt <= '0;
    else if (!en || bit_tick)
      edge_cnt <= '0;
    else
      edge_cnt <= edge_cnt + 1'b1;
  end

  // Index only moves while serializing data and is parked at 0 otherwise.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      bit_idx <= '0;
    else if (!in_data)
      bit_idx <= '0;
    else if (bit_tick)
      bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: latches a byte on Data_Valid and serializes start, data
// (LSB first), optional parity and stop, each bit held for the latched prescale.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int prescale_w = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_W-1:0]     P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [prescale_w-1:0] Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  // state     | meaning
  // ST_IDLE   | line high, waiting for Data_Valid
  // ST_START  | start bit (low)
  // ST_DATA   | data bit bit_idx of latched byte
  // ST_PARITY | parity bit of latched byte
  // ST_STOP   | stop bit (high)

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  uart_state_e           state_q, state_d;
  logic                  tx_q, tx_d;
  logic [DATA_W-1:0]     data_q;
  logic                  par_en_q, par_typ_q;
  logic [prescale_w-1:0] prescale_q, prescale_eff;
  logic                  accept, parity_bit;
  logic                  bit_tick, last_bit;
  logic [IDX_W-1:0]      bit_idx, idx_inc;

  assign accept       = (state_q == ST_IDLE) && Data_Valid;
  assign prescale_eff = (Prescale < prescale_w'(MIN_PRESCALE)) ? prescale_w'(MIN_PRESCALE) : Prescale;
  assign parity_bit   = (^data_q) ^ (par_typ_q == PAR_ODD);
  assign idx_inc      = bit_idx + 1'b1;
  assign TX_OUT       = tx_q;
  assign Busy         = (state_q != ST_IDLE);

  uart_tx_bit_timer #(
    .DATA_W     (DATA_W),
    .prescale_w (prescale_w),
    .IDX_W      (IDX_W)
  ) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .en       (state_q != ST_IDLE),
    .in_data  (state_q == ST_DATA),
    .prescale (prescale_q),
    .bit_tick (bit_tick),
    .bit_idx  (bit_idx),
    .last_bit (last_bit)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= '0;
    end else if (accept) begin
      data_q     <= P_DATA;
      par_en_q   <= PAR_EN;
      par_typ_q  <= PAR_TYP;
      prescale_q <= prescale_eff;
    end
  end

  // tx_d is the line value for the state being entered, so TX_OUT is a pure flop.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (Data_Valid) begin
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: if (bit_tick) begin
        state_d = ST_DATA;
        tx_d    = data_q[0];
      end
      ST_DATA: if (bit_tick) begin
        if (!last_bit) begin
          tx_d = data_q[idx_inc];
        end else if (par_en_q) begin
          state_d = ST_PARITY;
          tx_d    = parity_bit;
        end else begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_PARITY: if (bit_tick) begin
        state_d = ST_STOP;
        tx_d    = 1'b1;
      end
      ST_STOP: if (bit_tick) begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: checks line value and Busy every cycle of each frame.
module tb_uart_tx_frame;
  import uart_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = '0;
  logic       TX_OUT;
  logic       Busy;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_frame #(.DATA_W(8), .prescale_w(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic [5:0] ps, input logic hold);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Prescale   = ps;
    Data_Valid = 1'b1;
    @(negedge CLK);
    if (!hold) Data_Valid = 1'b0;
  endtask

  // Expects the full frame starting now; optionally pokes inputs at cycle poke_at.
  task automatic frame(input string name, input logic [7:0] d, input logic has_par,
                       input logic exp_par, input int p, input int poke_at,
                       input logic [7:0] poke_data, input logic [5:0] poke_ps,
                       input logic poke_dv, input logic keep_dv);
    logic [10:0] bits;
    int nb;
    int k;
    bits = '0;
    nb = has_par ? 11 : 10;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    if (has_par) begin
      bits[9]  = exp_par;
      bits[10] = 1'b1;
    end else begin
      bits[9] = 1'b1;
    end
    k = 0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < p; c++) begin
        chk($sformatf("%s tx bit%0d cyc%0d", name, b, c), TX_OUT, bits[b]);
        chk($sformatf("%s busy bit%0d cyc%0d", name, b, c), Busy, 1'b1);
        if (k == poke_at) begin
          P_DATA     = poke_data;
          Prescale   = poke_ps;
          Data_Valid = poke_dv;
        end
        if (k == poke_at + 1 && !keep_dv) Data_Valid = 1'b0;
        k++;
        @(negedge CLK);
      end
    end
    chk($sformatf("%s idle tx", name), TX_OUT, 1'b1);
    chk($sformatf("%s idle busy", name), Busy, 1'b0);
  endtask

  initial begin
    #12;
    chk("reset tx", TX_OUT, 1'b1);
    chk("reset busy", Busy, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("post-reset tx", TX_OUT, 1'b1);
    chk("post-reset busy", Busy, 1'b0);

    // 0xA5 has four ones: even parity bit 0, odd parity bit 1
    send(8'hA5, 1'b1, PAR_EVEN, 6'd8, 1'b0);
    frame("even_a5", 8'hA5, 1'b1, 1'b0, 8, -1, 8'h00, 6'd8, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);

    send(8'hA5, 1'b1, PAR_ODD, 6'd8, 1'b0);
    frame("odd_a5", 8'hA5, 1'b1, 1'b1, 8, -1, 8'h00, 6'd8, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);

    // Request of 0xFF during the frame must be ignored
    send(8'h00, 1'b0, PAR_EVEN, 6'd16, 1'b0);
    frame("nopar_00", 8'h00, 1'b0, 1'b0, 16, 40, 8'hFF, 6'd16, 1'b1, 1'b0);
    repeat (3) @(negedge CLK);
    chk("ignored req tx", TX_OUT, 1'b1);
    chk("ignored req busy", Busy, 1'b0);

    // Back-to-back with Data_Valid held: one idle cycle between frames
    send(8'h55, 1'b0, PAR_EVEN, 6'd4, 1'b1);
    frame("b2b_55", 8'h55, 1'b0, 1'b0, 4, 5, 8'h0F, 6'd4, 1'b1, 1'b1);
    @(negedge CLK);
    Data_Valid = 1'b0;
    frame("b2b_0f", 8'h0F, 1'b0, 1'b0, 4, -1, 8'h0F, 6'd4, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);

    // Prescale=2 clamps to 4; mid-frame change to 8 has no effect
    send(8'h96, 1'b0, PAR_EVEN, 6'd2, 1'b0);
    frame("clamp_96", 8'h96, 1'b0, 1'b0, 4, 10, 8'h96, 6'd8, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);

    // Reset during data bit 2 of 0xC3 (bit value 0)
    send(8'hC3, 1'b0, PAR_EVEN, 6'd8, 1'b0);
    repeat (26) @(negedge CLK);
    chk("pre-reset tx", TX_OUT, 1'b0);
    chk("pre-reset busy", Busy, 1'b1);
    #2;
    RST = 1'b0;
    #1;
    chk("async reset tx", TX_OUT, 1'b1);
    chk("async reset busy", Busy, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("after reset tx", TX_OUT, 1'b1);
    chk("after reset busy", Busy, 1'b0);

    // 0x3C has four ones: even parity bit 0
    send(8'h3C, 1'b1, PAR_EVEN, 6'd8, 1'b0);
    frame("post_rst_3c", 8'h3C, 1'b1, 1'b0, 8, -1, 8'h00, 6'd8, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
